postif_ibuf: RTL and testbench

//  Post-IF stage with a parametrised instruction buffer between the I-cache reply and ID.

---
 rtl/postif_ibuf.sv | 132 +++++++++++++
 tb/tb_postif_ibuf.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/postif_ibuf.sv
// Post-IF instruction buffer: queues completed fetch slots for ID, drops stale
// cache replies after a flush, and produces the PC/IF stall.
module postif_ibuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int EXC_W  = 32,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         inst_i,
    input  logic [EXC_W-1:0]    exception_type_i,
    input  logic                inst_ren_i,
    input  logic                inst_ok_i,
    input  logic                inst_valid_i,
    input  logic                flush_i,
    input  logic                id_ready_i,
    output logic [31:0]         pc_o,
    output logic [31:0]         inst_o,
    output logic [EXC_W-1:0]    exception_type_o,
    output logic                inst_valid_o,
    output logic                postif_stall_o,
    output logic [ADDR_W:0]     count_o,
    output logic                overflow_o
);

    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [EXC_W-1:0] exc_mem_q  [DEPTH];
    logic [31:0]      pc_mem_d   [DEPTH];
    logic [31:0]      inst_mem_d [DEPTH];
    logic [EXC_W-1:0] exc_mem_d  [DEPTH];

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              drop_q, drop_d;
    logic              overflow_q, overflow_d;

    logic        done, push, pop, empty, full, byp, head_valid, wr_en;
    logic [31:0] inst_in;

    always_comb begin
        done       = inst_valid_i & (~inst_ren_i | inst_ok_i);
        push       = done & ~drop_q & ~flush_i;
        empty      = (count_q == '0);
        full       = (count_q == (ADDR_W+1)'(DEPTH));
        byp        = empty & push & (BYPASS != 0);
        head_valid = (~empty | byp) & ~flush_i;
        pop        = head_valid & id_ready_i & ~flush_i;
        // Exception slots never touched the cache, so their instruction word is meaningless.
        inst_in    = inst_ren_i ? inst_i : 32'h0;
    end

    always_comb begin
        pc_o             = 32'h0;
        inst_o           = 32'h0;
        exception_type_o = '0;
        if (!empty) begin
            pc_o             = pc_mem_q[rd_ptr_q];
            inst_o           = inst_mem_q[rd_ptr_q];
            exception_type_o = exc_mem_q[rd_ptr_q];
        end else if (byp) begin
            pc_o             = pc_i;
            inst_o           = inst_in;
            exception_type_o = exception_type_i;
        end
        inst_valid_o   = head_valid;
        postif_stall_o = (inst_ren_i & ~inst_ok_i) | drop_q | (full & ~pop);
        count_o        = count_q;
        overflow_o     = overflow_q;
    end

    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        exc_mem_d  = exc_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        overflow_d = push & full & ~pop;
        // A bypassed slot consumed by ID in the same cycle never enters storage.
        wr_en      = push & (~full | pop) & ~(byp & pop);

        if (drop_q && inst_ok_i)
            drop_d = 1'b0;
        if (flush_i && inst_ren_i && !inst_ok_i)
            drop_d = 1'b1;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                pc_mem_d[wr_ptr_q]   = pc_i;
                inst_mem_d[wr_ptr_q] = inst_in;
                exc_mem_d[wr_ptr_q]  = exception_type_i;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop && !byp)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop & ~byp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                exc_mem_q[i]  <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
            exc_mem_q  <= exc_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_postif_ibuf.sv
// Directed bench for postif_ibuf (DEPTH=4, BYPASS=1): bypass, fill/overflow,
// wrap-around, flush/drop, exception slots and reset.
module tb_postif_ibuf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, inst_i, exception_type_i;
    logic        inst_ren_i, inst_ok_i, inst_valid_i, flush_i, id_ready_i;
    logic [31:0] pc_o, inst_o, exception_type_o;
    logic        inst_valid_o, postif_stall_o, overflow_o;
    logic [2:0]  count_o;

    int n_cmp = 0;
    int n_err = 0;

    postif_ibuf #(.DEPTH(4), .ADDR_W(2), .EXC_W(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
        .exception_type_i(exception_type_i), .inst_ren_i(inst_ren_i),
        .inst_ok_i(inst_ok_i), .inst_valid_i(inst_valid_i), .flush_i(flush_i),
        .id_ready_i(id_ready_i), .pc_o(pc_o), .inst_o(inst_o),
        .exception_type_o(exception_type_o), .inst_valid_o(inst_valid_o),
        .postif_stall_o(postif_stall_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_i = '0; inst_i = '0; exception_type_i = '0;
        inst_ren_i = 0; inst_ok_i = 0; inst_valid_i = 0; flush_i = 0;
    endtask

    task automatic slot(input logic [31:0] pc, input logic [31:0] inst);
        pc_i = pc; inst_i = inst; exception_type_i = '0;
        inst_ren_i = 1; inst_ok_i = 1; inst_valid_i = 1; flush_i = 0;
    endtask

    initial begin
        rst = 1; id_ready_i = 0; idle();
        tick(); tick();
        #1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_valid", 32'(inst_valid_o), 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        rst = 0;

        // 1: bypass consume on an empty buffer
        id_ready_i = 1; slot(32'hBFC00000, 32'h24080001);
        #1;
        chk("byp_valid", 32'(inst_valid_o), 1);
        chk("byp_pc", pc_o, 32'hBFC00000);
        chk("byp_inst", inst_o, 32'h24080001);
        tick(); idle(); #1;
        chk("byp_count", 32'(count_o), 0);
        chk("byp_after_valid", 32'(inst_valid_o), 0);

        // 2: fill, overflow, drain
        id_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            slot(32'(i*4), 32'h100 + 32'(i));
            tick();
        end
        idle(); #1;
        chk("fill_count", 32'(count_o), 4);
        chk("fill_stall", 32'(postif_stall_o), 1);
        chk("fill_head", pc_o, 0);
        slot(32'h20, 32'h120);
        #1;
        chk("ovf_stall", 32'(postif_stall_o), 1);
        tick(); idle(); #1;
        chk("ovf_pulse", 32'(overflow_o), 1);
        chk("ovf_count", 32'(count_o), 4);
        tick();
        chk("ovf_clear", 32'(overflow_o), 0);
        id_ready_i = 1; #1;
        chk("pop_stall", 32'(postif_stall_o), 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", pc_o, 32'(i*4));
            chk("drain_inst", inst_o, 32'h100 + 32'(i));
            tick();
        end
        chk("drain_valid", 32'(inst_valid_o), 0);
        chk("drain_count", 32'(count_o), 0);

        // 3: push+pop while full, with pointer wrap
        id_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            slot(32'(i*4), 32'h200 + 32'(i));
            tick();
        end
        id_ready_i = 1; slot(32'h10, 32'h210); #1;
        chk("fpp_head", pc_o, 0);
        chk("fpp_stall", 32'(postif_stall_o), 0);
        tick(); idle(); #1;
        chk("fpp_count", 32'(count_o), 4);
        chk("fpp_ovf", 32'(overflow_o), 0);
        for (int i = 1; i < 5; i++) begin
            chk("wrap_pc", pc_o, 32'(i*4));
            tick();
        end
        chk("wrap_inst_last", inst_o, 0);
        chk("wrap_valid", 32'(inst_valid_o), 0);

        // 4: flush with an outstanding read, stale reply discarded
        slot(32'h40, 32'h0); inst_ok_i = 0; flush_i = 1; #1;
        chk("fl_stall", 32'(postif_stall_o), 1);
        chk("fl_valid", 32'(inst_valid_o), 0);
        tick(); idle(); #1;
        chk("fl_count", 32'(count_o), 0);
        chk("drop_stall1", 32'(postif_stall_o), 1);
        tick();
        chk("drop_stall2", 32'(postif_stall_o), 1);
        tick();
        slot(32'h44, 32'hDEADBEEF); #1;
        chk("stale_valid", 32'(inst_valid_o), 0);
        tick(); idle(); #1;
        chk("drop_clear", 32'(postif_stall_o), 0);
        chk("stale_count", 32'(count_o), 0);
        id_ready_i = 0; slot(32'h80, 32'h11); #1;
        chk("r80_byp_pc", pc_o, 32'h80);
        tick(); idle(); #1;
        chk("r80_count", 32'(count_o), 1);
        chk("r80_pc", pc_o, 32'h80);
        id_ready_i = 1; tick(); id_ready_i = 0;
        chk("r80_pop", 32'(count_o), 0);

        // 5: exception slot without cache access
        pc_i = 32'h90; inst_i = 32'hFFFFFFFF; exception_type_i = 32'h4;
        inst_ren_i = 0; inst_ok_i = 0; inst_valid_i = 1; #1;
        chk("exc_byp_inst", inst_o, 0);
        chk("exc_byp_code", exception_type_o, 32'h4);
        tick(); idle(); #1;
        chk("exc_inst", inst_o, 0);
        chk("exc_code", exception_type_o, 32'h4);
        chk("exc_pc", pc_o, 32'h90);

        // 6: reset with occupancy, then reset with drop pending
        slot(32'hA0, 32'h1); tick();
        slot(32'hA4, 32'h2); tick(); idle(); #1;
        chk("pre_rst_count", 32'(count_o), 3);
        rst = 1; tick(); rst = 0; #1;
        chk("rst3_count", 32'(count_o), 0);
        chk("rst3_valid", 32'(inst_valid_o), 0);
        slot(32'hB0, 32'h0); inst_ok_i = 0; flush_i = 1; tick(); idle(); #1;
        chk("pre_rst_drop", 32'(postif_stall_o), 1);
        rst = 1; tick(); rst = 0; #1;
        chk("rst_drop_stall", 32'(postif_stall_o), 0);
        chk("rst_drop_count", 32'(count_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
